fpalu_issue_q: RTL

- Operand-issue and result-collection stage that sits directly around the FPALU in the FIR datapath.
- Accepts op requests with a valid/ready handshake. Each operand is either IEEE FP16 (unpacked here into the FP29i unified format) or an FP29i value fed back from the accumulator.
- Queues requests, issues at most one per cycle into the FPALU, and tracks the FPALU's fixed pipeline latency with a valid/tag shadow pipe.
- Captures FPALU results into a result queue with valid/ready output and credit-based flow control, because the FPALU cannot stall.

---
 rtl/fpalu_pkg.sv | 72 +++++++
 rtl/fpalu_issue_q_if.sv | 55 +++++
 rtl/fpq_fifo.sv | 52 +++++
 rtl/fpalu_issue_q.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fpalu_pkg.sv
// Shared widths, unpack constants and types for the FPALU issue/collect stage.
//   fp16_unpack  : IEEE FP16 -> FP29i {sgn, exp[5:0], man_dn[21:0]}
//   fp16_special : FP16 operand is Inf/NaN
package fpalu_pkg;

    localparam int unsigned FP16_SGN_W = 1;
    localparam int unsigned FP16_EXP_W = 5;
    localparam int unsigned FP16_MAN_W = 10;
    localparam int unsigned FP16_W     = FP16_SGN_W + FP16_EXP_W + FP16_MAN_W;

    localparam int unsigned UNI_SGN_W  = 1;
    localparam int unsigned UNI_EXP_W  = 6;
    localparam int unsigned UNI_MAN_W  = 22;
    localparam int unsigned UNI_W      = UNI_SGN_W + UNI_EXP_W + UNI_MAN_W;

    localparam int unsigned FP16_BIAS  = 15;
    localparam int unsigned UNI_BIAS   = 31;

    localparam int unsigned UNPACK_REBIAS = UNI_BIAS - FP16_BIAS;  // 16
    localparam int unsigned DENORM_EXP    = UNPACK_REBIAS + 1;     // 17
    localparam int unsigned INF_EXP       = 31 + UNPACK_REBIAS;    // 47

    // Zero padding below the FP16 mantissa inside man_dn.
    localparam int unsigned MAN_PAD_W = UNI_MAN_W - 1 - FP16_MAN_W;

    localparam int unsigned ALU_LAT_DEF = 4;

    typedef struct packed {
        logic                 sgn;
        logic [UNI_EXP_W-1:0] exp;
        logic [UNI_MAN_W-1:0] man_dn;
    } uni_t;

    // Input-queue payload (tag travels alongside, its width is a parameter).
    typedef struct packed {
        logic op;
        logic exc;
        uni_t a;
        uni_t b;
    } iq_ops_t;

    // Result-queue payload (tag travels alongside).
    typedef struct packed {
        uni_t y;
        logic exc;
    } rq_data_t;

    function automatic logic fp16_special(input logic [FP16_W-1:0] h);
        return h[FP16_W-2 -: FP16_EXP_W] == {FP16_EXP_W{1'b1}};
    endfunction

    function automatic uni_t fp16_unpack(input logic [FP16_W-1:0] h);
        uni_t                  u;
        logic [FP16_EXP_W-1:0] e;
        logic [FP16_MAN_W-1:0] m;
        e = h[FP16_W-2 -: FP16_EXP_W];
        m = h[FP16_MAN_W-1:0];
        u.sgn = h[FP16_W-1];
        if (e == '0) begin
            u.exp    = UNI_EXP_W'(DENORM_EXP);
            u.man_dn = {1'b0, m, {MAN_PAD_W{1'b0}}};
        end else if (e == {FP16_EXP_W{1'b1}}) begin
            u.exp    = UNI_EXP_W'(INF_EXP);
            u.man_dn = {1'b1, m, {MAN_PAD_W{1'b0}}};
        end else begin
            u.exp    = UNI_EXP_W'(e) + UNI_EXP_W'(UNPACK_REBIAS);
            u.man_dn = {1'b1, m, {MAN_PAD_W{1'b0}}};
        end
        return u;
    endfunction

endpackage

// File: rtl/fpalu_issue_q_if.sv
// Request / FPALU / result signal bundle of fpalu_issue_q.
//   master : environment side (drives requests, FPALU result, res_ready)
//   slave  : fpalu_issue_q side
interface fpalu_issue_q_if
    import fpalu_pkg::*;
#(
    parameter int unsigned TAG_W = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_op;
    logic                  in_a_sel_uni;
    logic [FP16_W-1:0]     in_a_fp16;
    logic [UNI_W-1:0]      in_a_uni;
    logic                  in_b_sel_uni;
    logic [FP16_W-1:0]     in_b_fp16;
    logic [UNI_W-1:0]      in_b_uni;
    logic [TAG_W-1:0]      in_tag;

    logic                  alu_a_sgn;
    logic [UNI_EXP_W-1:0]  alu_a_exp;
    logic [UNI_MAN_W-1:0]  alu_a_man_dn;
    logic                  alu_b_sgn;
    logic [UNI_EXP_W-1:0]  alu_b_exp;
    logic [UNI_MAN_W-1:0]  alu_b_man_dn;
    logic                  alu_add_muln;
    logic                  alu_y_sgn;
    logic [UNI_EXP_W-1:0]  alu_y_exp;
    logic [UNI_MAN_W-1:0]  alu_y_man_dn;

    logic                  res_valid;
    logic                  res_ready;
    logic [UNI_W-1:0]      res_uni;
    logic [TAG_W-1:0]      res_tag;
    logic                  res_exc;

    modport master (
        output in_valid, in_op, in_a_sel_uni, in_a_fp16, in_a_uni,
               in_b_sel_uni, in_b_fp16, in_b_uni, in_tag,
               alu_y_sgn, alu_y_exp, alu_y_man_dn, res_ready,
        input  in_ready, alu_a_sgn, alu_a_exp, alu_a_man_dn,
               alu_b_sgn, alu_b_exp, alu_b_man_dn, alu_add_muln,
               res_valid, res_uni, res_tag, res_exc
    );

    modport slave (
        input  in_valid, in_op, in_a_sel_uni, in_a_fp16, in_a_uni,
               in_b_sel_uni, in_b_fp16, in_b_uni, in_tag,
               alu_y_sgn, alu_y_exp, alu_y_man_dn, res_ready,
        output in_ready, alu_a_sgn, alu_a_exp, alu_a_man_dn,
               alu_b_sgn, alu_b_exp, alu_b_man_dn, alu_add_muln,
               res_valid, res_uni, res_tag, res_exc
    );

endinterface

// File: rtl/fpq_fifo.sv
// Synchronous FIFO, power-of-2 depth, registered head, occupancy count.
//   wr_en/wr_data : push (ignored when full unless popping the same cycle)
//   rd_en/rd_data : pop (ignored when empty); rd_data is the current head
//   count         : registered occupancy
module fpq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [W-1:0]                 wr_data,
    input  logic                         rd_en,
    output logic [W-1:0]                 rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == CNT_W'(DEPTH));
    assign do_rd = rd_en && (count != '0);
    assign do_wr = wr_en && (!full || do_rd);

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

    // Storage: contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fpalu_issue_q.sv
// Operand issue and result collection around the fixed-latency FPALU.
//   clk, rst_n : clock, async active-low reset
//   bus.in_*   : request handshake with FP16/FP29i operands and user tag
//   bus.alu_*  : operands/mode to the FPALU and its result (ALU_LAT later)
//   bus.res_*  : result queue head with valid/ready handshake
module fpalu_issue_q
    import fpalu_pkg::*;
#(
    parameter int unsigned IQ_DEPTH = 4,
    parameter int unsigned RQ_DEPTH = 8,
    parameter int unsigned ALU_LAT  = ALU_LAT_DEF,
    parameter int unsigned TAG_W    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    fpalu_issue_q_if.slave bus
);

    localparam int unsigned IQ_CNT_W = $clog2(IQ_DEPTH + 1);
    localparam int unsigned RQ_CNT_W = $clog2(RQ_DEPTH + 1);
    localparam int unsigned CRED_W   = RQ_CNT_W + 1;
    localparam int unsigned IQ_W     = $bits(iq_ops_t) + TAG_W;
    localparam int unsigned RQ_W     = $bits(rq_data_t) + TAG_W;

    // Operand unpack ahead of the input queue.
    iq_ops_t enq_ops;
    always_comb begin
        enq_ops.op  = bus.in_op;
        enq_ops.a   = bus.in_a_sel_uni ? uni_t'(bus.in_a_uni) : fp16_unpack(bus.in_a_fp16);
        enq_ops.b   = bus.in_b_sel_uni ? uni_t'(bus.in_b_uni) : fp16_unpack(bus.in_b_fp16);
        enq_ops.exc = (!bus.in_a_sel_uni && fp16_special(bus.in_a_fp16))
                   || (!bus.in_b_sel_uni && fp16_special(bus.in_b_fp16));
    end

    // Input queue.
    logic [IQ_CNT_W-1:0] iq_count;
    logic [IQ_W-1:0]     iq_head;
    iq_ops_t             head_ops;
    logic [TAG_W-1:0]    head_tag;
    logic                iq_push;
    logic                issue;

    assign bus.in_ready = (iq_count < IQ_CNT_W'(IQ_DEPTH));
    assign iq_push      = bus.in_valid && bus.in_ready;

    fpq_fifo #(.DEPTH(IQ_DEPTH), .W(IQ_W)) u_iq (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (iq_push),
        .wr_data ({bus.in_tag, enq_ops}),
        .rd_en   (issue),
        .rd_data (iq_head),
        .count   (iq_count)
    );

    assign {head_tag, head_ops} = iq_head;

    // Credit check: every in-flight op already owns a result-queue slot.
    logic [RQ_CNT_W-1:0] inflight_cnt;
    logic [RQ_CNT_W-1:0] rq_count;
    logic [CRED_W-1:0]   credit_used;

    assign credit_used = CRED_W'(inflight_cnt) + CRED_W'(rq_count);
    assign issue       = (iq_count != '0) && (credit_used < CRED_W'(RQ_DEPTH));

    // FPALU drive: head entry while issuing, idle encoding otherwise.
    always_comb begin
        bus.alu_a_sgn    = 1'b0;
        bus.alu_a_exp    = '0;
        bus.alu_a_man_dn = '0;
        bus.alu_b_sgn    = 1'b0;
        bus.alu_b_exp    = '0;
        bus.alu_b_man_dn = '0;
        bus.alu_add_muln = 1'b1;
        if (issue) begin
            bus.alu_a_sgn    = head_ops.a.sgn;
            bus.alu_a_exp    = head_ops.a.exp;
            bus.alu_a_man_dn = head_ops.a.man_dn;
            bus.alu_b_sgn    = head_ops.b.sgn;
            bus.alu_b_exp    = head_ops.b.exp;
            bus.alu_b_man_dn = head_ops.b.man_dn;
            bus.alu_add_muln = head_ops.op;
        end
    end

    // Shadow pipe mirroring the FPALU latency.
    logic [ALU_LAT-1:0]            sh_vld;
    logic [ALU_LAT-1:0]            sh_exc;
    logic [ALU_LAT-1:0][TAG_W-1:0] sh_tag;
    logic                          retire;

    assign retire = sh_vld[ALU_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_vld       <= '0;
            sh_exc       <= '0;
            sh_tag       <= '0;
            inflight_cnt <= '0;
        end else begin
            sh_vld[0] <= issue;
            sh_exc[0] <= head_ops.exc;
            sh_tag[0] <= head_tag;
            for (int unsigned i = 1; i < ALU_LAT; i++) begin
                sh_vld[i] <= sh_vld[i-1];
                sh_exc[i] <= sh_exc[i-1];
                sh_tag[i] <= sh_tag[i-1];
            end
            inflight_cnt <= inflight_cnt + RQ_CNT_W'(issue) - RQ_CNT_W'(retire);
        end
    end

    // Result queue.
    rq_data_t         rq_wr;
    rq_data_t         rq_head;
    logic [TAG_W-1:0] rq_head_tag;
    logic [RQ_W-1:0]  rq_rd;
    logic             rq_pop;

    always_comb begin
        rq_wr.y.sgn    = bus.alu_y_sgn;
        rq_wr.y.exp    = bus.alu_y_exp;
        rq_wr.y.man_dn = bus.alu_y_man_dn;
        rq_wr.exc      = sh_exc[ALU_LAT-1];
    end

    assign bus.res_valid = (rq_count != '0);
    assign rq_pop        = bus.res_valid && bus.res_ready;

    fpq_fifo #(.DEPTH(RQ_DEPTH), .W(RQ_W)) u_rq (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (retire),
        .wr_data ({sh_tag[ALU_LAT-1], rq_wr}),
        .rd_en   (rq_pop),
        .rd_data (rq_rd),
        .count   (rq_count)
    );

    assign {rq_head_tag, rq_head} = rq_rd;

    // Result outputs read as zero while the queue is empty.
    always_comb begin
        bus.res_uni = '0;
        bus.res_tag = '0;
        bus.res_exc = 1'b0;
        if (bus.res_valid) begin
            bus.res_uni = rq_head.y;
            bus.res_tag = rq_head_tag;
            bus.res_exc = rq_head.exc;
        end
    end

endmodule
